// File: rtl/conv_sched_pkg.sv
// Shared encodings and widths for the CNN layer sequencer and conv_sum.
// Layer-state values are single-sourced here so both blocks agree on the bus.
package conv_sched_pkg;

  localparam int STATE_W = 4;
  localparam int PIX_W   = 12;
  localparam int OCH_W   = 5;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 4'd0,
    PADDING = 4'd1,
    CONV1   = 4'd2,
    RES_1   = 4'd3,
    RES_2   = 4'd4,
    UP_1    = 4'd5,
    UP_2    = 4'd6,
    CONV2   = 4'd7,
    FINISH  = 4'd8
  } layer_state_e;

  // Layers that scan the image and issue SRAM read beats.
  function automatic logic is_conv_layer(input layer_state_e s);
    return (s inside {CONV1, RES_1, RES_2, UP_1, UP_2, CONV2});
  endfunction

endpackage

// File: rtl/sched_valid_pipe.sv
// DEPTH-stage shift register carrying {valid, pix, och} from read issue to write-back.
// Synchronous active-high reset flushes valid bits and data.
module sched_valid_pipe
  import conv_sched_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [PIX_W-1:0] in_pix_i,
  input  logic [OCH_W-1:0] in_och_i,
  output logic             out_valid_o,
  output logic [PIX_W-1:0] out_pix_o,
  output logic [OCH_W-1:0] out_och_o
);

  logic [DEPTH-1:0] valid_q;
  logic [PIX_W-1:0] pix_q [DEPTH];
  logic [OCH_W-1:0] och_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pix_q[i] <= '0;
        och_q[i] <= '0;
      end
    end else begin
      valid_q  <= {valid_q[DEPTH-2:0], in_valid_i};
      pix_q[0] <= in_pix_i;
      och_q[0] <= in_och_i;
      for (int i = 1; i < DEPTH; i++) begin
        pix_q[i] <= pix_q[i-1];
        och_q[i] <= och_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_pix_o   = pix_q[DEPTH-1];
  assign out_och_o   = och_q[DEPTH-1];

endmodule

// File: rtl/conv_layer_sched.sv
// Layer sequencer: walks PADDING/CONV/RES/UP layers, issues read beats, aligns write-back.
// Optional busy-cycle counter enabled by defining SCHED_PERF_CNT_EN.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int IMG_W     = 48,
  parameter int IMG_H     = 48,
  parameter int OCH_NUM   = 24,
  parameter int NUM_RES   = 8,
  parameter int PIPE_LAT  = 6,
  parameter int PAD_BEATS = 196
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [PIX_W-1:0]   rd_pix,
  output logic [OCH_W-1:0]   rd_och,
  output logic [2:0]         res_idx,
  output logic               wr_en,
  output logic [PIX_W-1:0]   wr_pix,
  output logic [OCH_W-1:0]   wr_och,
  output logic [31:0]        perf_cycles
);

  localparam int IFL_W = $clog2(PIPE_LAT + 1);
  localparam int PAD_W = $clog2(PAD_BEATS + 1);
  localparam logic [PIX_W-1:0] IMG_W_L  = PIX_W'(IMG_W);
  localparam logic [PIX_W-1:0] COL_LAST = PIX_W'(IMG_W - 1);
  localparam logic [PIX_W-1:0] ROW_LAST = PIX_W'(IMG_H - 1);
  localparam logic [OCH_W-1:0] OCH_LAST = OCH_W'(OCH_NUM - 1);
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_BEATS - 1);
  localparam logic [2:0]       RES_LAST = 3'(NUM_RES - 1);

  layer_state_e     state_q;
  logic             busy_q;
  logic             done_q;
  logic [PIX_W-1:0] col_q;
  logic [PIX_W-1:0] row_q;
  logic [OCH_W-1:0] och_q;
  logic             issue_done_q;
  logic [IFL_W-1:0] inflight_q;
  logic [IFL_W-1:0] inflight_d;
  logic [PAD_W-1:0] pad_cnt_q;
  logic [2:0]       res_q;

  logic             conv_layer;
  logic             rd_en_w;
  logic [PIX_W-1:0] rd_pix_w;
  logic             last_beat;
  logic             drained;
  logic             pipe_valid;
  logic [PIX_W-1:0] pipe_pix;
  logic [OCH_W-1:0] pipe_och;

  // A beat is issued in any cycle rd_en is high; stall withholds the beat
  // combinationally and the scan counters hold. Write-back ignores stall.
  assign conv_layer = is_conv_layer(state_q);
  assign rd_en_w    = conv_layer && !issue_done_q && !stall;
  assign rd_pix_w   = row_q * IMG_W_L + col_q;
  assign last_beat  = (col_q == COL_LAST) && (row_q == ROW_LAST) && (och_q == OCH_LAST);

  always_comb begin
    inflight_d = inflight_q;
    if (rd_en_w && !pipe_valid) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!rd_en_w && pipe_valid) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  // Looking at the next in-flight count lets the layer advance on the cycle of its final write.
  assign drained = issue_done_q && (inflight_d == '0);

  sched_valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_en_w),
    .in_pix_i    (rd_pix_w),
    .in_och_i    (och_q),
    .out_valid_o (pipe_valid),
    .out_pix_o   (pipe_pix),
    .out_och_o   (pipe_och)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      och_q        <= '0;
      issue_done_q <= 1'b0;
      inflight_q   <= '0;
      pad_cnt_q    <= '0;
      res_q        <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= inflight_d;

      if (rd_en_w) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q == ROW_LAST) begin
            row_q <= '0;
            och_q <= (och_q == OCH_LAST) ? '0 : och_q + 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (last_beat) begin
          issue_done_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= PADDING;
            busy_q    <= 1'b1;
            pad_cnt_q <= '0;
          end
        end
        PADDING: begin
          pad_cnt_q <= pad_cnt_q + 1'b1;
          if (pad_cnt_q == PAD_LAST) begin
            state_q <= CONV1;
          end
        end
        CONV1: if (drained) begin
          state_q      <= RES_1;
          issue_done_q <= 1'b0;
        end
        RES_1: if (drained) begin
          state_q      <= RES_2;
          issue_done_q <= 1'b0;
        end
        RES_2: if (drained) begin
          issue_done_q <= 1'b0;
          if (res_q < RES_LAST) begin
            res_q   <= res_q + 1'b1;
            state_q <= RES_1;
          end else begin
            res_q   <= '0;
            state_q <= UP_1;
          end
        end
        UP_1: if (drained) begin
          state_q      <= UP_2;
          issue_done_q <= 1'b0;
        end
        UP_2: if (drained) begin
          state_q      <= CONV2;
          issue_done_q <= 1'b0;
        end
        CONV2: if (drained) begin
          state_q      <= FINISH;
          issue_done_q <= 1'b0;
          done_q       <= 1'b1;
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_w;
  assign rd_pix  = rd_pix_w;
  assign rd_och  = och_q;
  assign res_idx = res_q;
  // PADDING writes bypass the pipe; its zero-write beats are indexed by the pad counter.
  assign wr_en   = pipe_valid || (state_q == PADDING);
  assign wr_pix  = (state_q == PADDING) ? PIX_W'(pad_cnt_q) : pipe_pix;
  assign wr_och  = (state_q == PADDING) ? '0 : pipe_och;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench for conv_layer_sched in a small configuration.
// Reference model tracks layer order, beat scan order and write-back timing with queues.
module tb_conv_layer_sched;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int OCH   = 2;
  localparam int NRES  = 1;
  localparam int LAT   = 3;
  localparam int PAD   = 16;
  localparam int BEATS = W * H * OCH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  state;
  logic        busy, done, rd_en, wr_en;
  logic [11:0] rd_pix, wr_pix;
  logic [4:0]  rd_och, wr_och;
  logic [2:0]  res_idx;
  logic [31:0] perf_cycles;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // clock/reset block
  always #5 clk = ~clk;

  conv_layer_sched #(
    .IMG_W     (W),
    .IMG_H     (H),
    .OCH_NUM   (OCH),
    .NUM_RES   (NRES),
    .PIPE_LAT  (LAT),
    .PAD_BEATS (PAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .state       (state),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_pix      (rd_pix),
    .rd_och      (rd_och),
    .res_idx     (res_idx),
    .wr_en       (wr_en),
    .wr_pix      (wr_pix),
    .wr_och      (wr_och),
    .perf_cycles (perf_cycles)
  );

  // driver: one call is one clock cycle; inputs change just after the edge, outputs sampled at negedge
  task automatic tick(input logic r, input logic s, input logic st);
    @(posedge clk);
    #1;
    rst   = r;
    start = s;
    stall = st;
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tests++;
    if ({state, busy, done, rd_en, wr_en} !== 8'd0) begin
      fails++;
      $display("FAIL reset_ctrl got state=%0d busy=%0b done=%0b rd=%0b wr=%0b exp all 0", state, busy, done, rd_en, wr_en);
    end
    tests++;
    if ({rd_pix, rd_och, res_idx, wr_pix, wr_och, perf_cycles} !== '0) begin
      fails++;
      $display("FAIL reset_data got rd_pix=%0d rd_och=%0d res=%0d wr_pix=%0d wr_och=%0d perf=%0d exp all 0",
               rd_pix, rd_och, res_idx, wr_pix, wr_och, perf_cycles);
    end
  endtask

  // Full inference against the reference model. fix_stall>=0 holds stall for 4 cycles
  // in CONV1 once that many beats are issued; abort returns mid-RES_2 with beats in flight.
  task automatic run_inference(input int stall_pct, input int fix_stall, input bit abort);
    int seq_st[$];
    int seq_res[$];
    int pend_due[$];
    int pend_pix[$];
    int pend_och[$];
    int idx, beats, pad_done, layer_len, layer_stalls, rd_obs, busy_cnt, done_cnt, fix_left, budget, cur;
    int e_pix, e_och, exp_perf;
    bit conv, nxt;
    logic st, exp_rd, exp_wr;

    seq_st.push_back(1); seq_res.push_back(0);
    seq_st.push_back(2); seq_res.push_back(0);
    for (int r = 0; r < NRES; r++) begin
      seq_st.push_back(3); seq_res.push_back(r);
      seq_st.push_back(4); seq_res.push_back(r);
    end
    for (int s = 5; s <= 8; s++) begin
      seq_st.push_back(s); seq_res.push_back(0);
    end
    seq_st.push_back(0); seq_res.push_back(0);

    tick(1'b0, 1'b1, 1'b0);
    tests++;
    if (state !== 4'd0) begin
      fails++;
      $display("FAIL start_idle got %0d exp 0", state);
    end

    idx = 0; beats = 0; pad_done = 0; layer_len = 0; layer_stalls = 0; rd_obs = 0;
    busy_cnt = 0; done_cnt = 0; budget = 0;
    fix_left = (fix_stall >= 0) ? 4 : 0;

    while (seq_st[idx] != 0) begin
      cur = seq_st[idx];
      st  = 1'b0;
      if (cur == 2 && fix_left > 0 && beats >= fix_stall) begin
        st = 1'b1;
        fix_left--;
      end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
        st = 1'b1;
      end
      tick(1'b0, ($urandom_range(0, 9) == 0), st);
      budget++;
      if (budget > 3000) begin
        tests++;
        fails++;
        $display("FAIL timeout state=%0d exp %0d after %0d cycles", state, cur, budget);
        return;
      end
      layer_len++;
      busy_cnt++;
      conv = (cur >= 2 && cur <= 7);

      tests++;
      if (state !== 4'(cur)) begin
        fails++;
        $display("FAIL state cyc=%0d got %0d exp %0d", cyc, state, cur);
      end
      tests++;
      if (busy !== 1'b1 || done !== (cur == 8)) begin
        fails++;
        $display("FAIL busy_done cyc=%0d got busy=%0b done=%0b exp busy=1 done=%0b", cyc, busy, done, cur == 8);
      end
      tests++;
      if (res_idx !== 3'(seq_res[idx])) begin
        fails++;
        $display("FAIL res_idx cyc=%0d got %0d exp %0d", cyc, res_idx, seq_res[idx]);
      end

      exp_rd = conv && beats < BEATS && !st;
      tests++;
      if (rd_en !== exp_rd) begin
        fails++;
        $display("FAIL rd_en cyc=%0d state=%0d got %0b exp %0b", cyc, cur, rd_en, exp_rd);
      end
      if (conv && beats < BEATS) begin
        e_pix = beats % (W * H);
        e_och = beats / (W * H);
        tests++;
        if (rd_pix !== 12'(e_pix) || rd_och !== 5'(e_och)) begin
          fails++;
          $display("FAIL rd_addr cyc=%0d got pix=%0d och=%0d exp pix=%0d och=%0d", cyc, rd_pix, rd_och, e_pix, e_och);
        end
        if (st) layer_stalls++;
      end
      if (rd_en === 1'b1) rd_obs++;
      if (exp_rd) begin
        pend_due.push_back(cyc + LAT);
        pend_pix.push_back(beats % (W * H));
        pend_och.push_back(beats / (W * H));
        beats++;
      end

      exp_wr = (cur == 1) || (pend_due.size() > 0 && pend_due[0] == cyc);
      tests++;
      if (wr_en !== exp_wr) begin
        fails++;
        $display("FAIL wr_en cyc=%0d state=%0d got %0b exp %0b", cyc, cur, wr_en, exp_wr);
      end
      if (cur != 1 && exp_wr) begin
        tests++;
        if (wr_pix !== 12'(pend_pix[0]) || wr_och !== 5'(pend_och[0])) begin
          fails++;
          $display("FAIL wr_addr cyc=%0d got pix=%0d och=%0d exp pix=%0d och=%0d", cyc, wr_pix, wr_och, pend_pix[0], pend_och[0]);
        end
        void'(pend_due.pop_front());
        void'(pend_pix.pop_front());
        void'(pend_och.pop_front());
      end
      if (done === 1'b1) done_cnt++;

      nxt = 1'b0;
      if (cur == 1) begin
        pad_done++;
        nxt = (pad_done == PAD);
      end else if (conv) begin
        if (beats == BEATS && pend_due.size() == 0) begin
          tests++;
          if (layer_len != BEATS + LAT + layer_stalls) begin
            fails++;
            $display("FAIL layer_len state=%0d got %0d exp %0d", cur, layer_len, BEATS + LAT + layer_stalls);
          end
          tests++;
          if (rd_obs != BEATS) begin
            fails++;
            $display("FAIL beat_count state=%0d got %0d exp %0d", cur, rd_obs, BEATS);
          end
          nxt = 1'b1;
        end
      end else begin
        nxt = 1'b1;
      end
      if (abort && cur == 4 && beats == 5) return;
      if (nxt) begin
        idx++;
        beats = 0; layer_len = 0; layer_stalls = 0; rd_obs = 0;
      end
    end

    tick(1'b0, 1'b0, 1'b0);
    tests++;
    if (state !== 4'd0 || busy !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("FAIL end_idle got state=%0d busy=%0b wr=%0b rd=%0b exp 0 0 0 0", state, busy, wr_en, rd_en);
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL done_pulses got %0d exp 1", done_cnt);
    end
`ifdef SCHED_PERF_CNT_EN
    exp_perf = busy_cnt;
`else
    exp_perf = 0;
`endif
    tests++;
    if (perf_cycles !== 32'(exp_perf)) begin
      fails++;
      $display("FAIL perf_cycles got %0d exp %0d", perf_cycles, exp_perf);
    end
  endtask

  task automatic test_sequence();
    run_inference(0, -1, 1'b0);
  endtask

  task automatic test_stall();
    run_inference(0, 5, 1'b0);
  endtask

  task automatic test_random_stall();
    run_inference(30, -1, 1'b0);
    run_inference(60, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int stray;
    run_inference(0, -1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tests++;
    if (state !== 4'd0 || wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort got state=%0d wr=%0b busy=%0b rd=%0b exp 0 0 0 0", state, wr_en, busy, rd_en);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (wr_en !== 1'b0 || state !== 4'd0) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL stray_writes got %0d exp 0", stray);
    end
    run_inference(20, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_random_stall();
    test_reset_mid();
    test_sequence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
